matrix_frame_capture: RTL
=========================

# matrix_frame_capture

Receive-side counterpart of the 8x8 RGB matrix driver. Monitors the driver's serial shift-register pins (DS, SH_CP, ST_CP, reset_out) and col_select, reconstructs each latched 24-bit column word and stores it in an 8-entry frame buffer. Sits beside `display8x8` for loopback self-test and simulation scoreboarding. Also flags malformed transfers.

## Interface
- No parameters; fixed 8 columns x 24 bits (red, green, blue).
- `clk`  input  1  system clock, same clock that drives `display8x8`.
- `reset`  input  1  synchronous, active-low reset.
- `DS`  input  1  serial data from the driver.
- `SH_CP`  input  1  shift clock; a rising edge shifts in DS.
- `ST_CP`  input  1  storage clock; a rising edge latches the column word.
- `reset_out`  input  1  driver's shift-register master reset, active-low.
- `col_select`  input  8  column enable, one-hot active-high, sampled with ST_CP.
- `rd_col`  input  3  frame-buffer read address.
- `rd_red`, `rd_green`, `rd_blue`  output  8 each  registered read data for `rd_col`.
- `col_valid`  output  8  columns written since the last frame_done.
- `frame_done`  output  1  one-cycle pulse when all 8 columns have been written.
- `frame_count`  output  8  completed frames, wraps 255->0.
- `err_len`  output  1  sticky: latch with bit count != 24.
- `err_col`  output  1  sticky: latch with col_select not one-hot.
- `err_clr`  input  1  clears err_len and err_col.

## Operation
- Input stage: DS, SH_CP, ST_CP, reset_out and col_select are registered once (s1), then once more (s2). Rising edge = s1 & ~s2.
- SH_CP rise: sr[23:0] <= {sr[22:0], DS_s1}. bit_cnt increments and saturates at 31.
- ST_CP rise: latched word = sr before any same-cycle shift. red=sr[23:16], green=sr[15:8], blue=sr[7:0], i.e. red MSB is shifted first.
  - If col_select_s1 is one-hot: write the word to entry index(col_select) and set col_valid[index].
  - If not one-hot: no write; set err_col.
  - If bit_cnt != 24: set err_len; the write still occurs when col is legal.
  - bit_cnt <= 0, or 1 if SH_CP also rose in that cycle.
- Simultaneous SH_CP and ST_CP rise: shift and latch both happen. Latch sees the pre-shift sr and bit_cnt, matching 74HC595 behaviour.
- More than 24 shifts: only the last 24 bits are retained.
- reset_out_s1 low: sr and bit_cnt clear. Edges are ignored while low. Frame buffer, col_valid and flags are untouched.
- Frame completion: when a write makes col_valid == 8'hFF:
  - frame_done pulses.
  - frame_count increments.
  - col_valid clears to 0 on the same edge.
- Rewriting an already-valid column overwrites the entry and does not advance completion.
- err_clr has priority over a same-cycle error set (flag reads 0 after).

## Timing
- Reset (reset==0 at a clk edge) drives:
  - sr, bit_cnt, col_valid, frame_count = 0.
  - frame_done, err_len, err_col = 0.
  - rd_* = 0.
  - s1/s2 = 0.
- Frame buffer contents after reset are 0. Reset mid-transfer discards partial bits.
- Latency without the sync option: a pin change sampled at edge N is seen as an edge in cycle N, and the action takes effect at edge N+1.
  - frame_done is high in the cycle after N+1.
  - rd_* reflects the new entry at edge N+2 when rd_col addresses it.
- Read port: rd_* is registered, one-cycle latency from rd_col.
- Transmitter requirement: SH_CP and ST_CP high and low for ≥2 clk each. DS stable ≥1 clk before and after the SH_CP rise (≥3 with sync).

## Configuration
- `MATRIX_CAPTURE_SYNC_EN` defined: a two-flop synchronizer precedes s1 on all inputs, adding 2 cycles to every latency above. Use this when the source is asynchronous or on another clock.
- Not defined: inputs feed s1 directly; same-clock source only.

## Test plan
- Shift 24 bits encoding red=8'hA5, green=8'h3C, blue=8'h0F, then ST_CP with col_select=8'h04 -> entry 2 reads A5/3C/0F. col_valid=8'h04. No errors.
- Write all 8 columns (col i: red=i) -> frame_done pulses once, frame_count=1, col_valid=0. Reading cols 0..7 returns red 0..7.
- 23 shifts then latch to col 0 -> err_len=1, entry written. Assert err_clr -> err_len=0.
- Latch with col_select=8'h06 -> err_col=1, no entry changes, col_valid unchanged.
- 24 shifts, then SH_CP and ST_CP rise together with DS=1 -> latched word is the 24-bit pre-shift value. bit_cnt=1 afterwards.
- 12 shifts, reset_out low 4 cycles, then 24 shifts and latch -> word equals the last 24 bits only, err_len=0. Repeat with reset low mid-transfer -> all outputs zero.

Source files
------------

// File: rtl/matrix_frame_capture.sv
// -----------------------------------------------------------------------------
// matrix_frame_capture
//
// Receive-side monitor for the 8x8 RGB matrix driver. Watches the driver's
// 74HC595-style serial pins, rebuilds every latched 24-bit column word and
// stores it in an 8-entry frame buffer. Also reports frame completion and
// flags malformed transfers (wrong bit count, illegal column select).
//
// Optional feature macro:
//   MATRIX_CAPTURE_SYNC_EN - when defined, a two-flop synchronizer sits in
//                            front of the s1 stage on every input, adding two
//                            cycles of latency. Leave undefined for a
//                            same-clock source.
//
// Ports:
//   clk          system clock (same clock as the driver)
//   reset        synchronous reset, active-low
//   DS           serial data
//   SH_CP        shift clock, rising edge shifts in DS
//   ST_CP        storage clock, rising edge latches the column word
//   reset_out    driver's shift-register master reset, active-low
//   col_select   one-hot column enable, sampled with ST_CP
//   rd_col       frame-buffer read address
//   rd_red/green/blue  registered read data for rd_col (1-cycle latency)
//   col_valid    columns written since the last completed frame
//   frame_done   one-cycle pulse when a frame completes
//   frame_count  completed frames, wraps 255->0
//   err_len      sticky: latch with bit count != 24
//   err_col      sticky: latch with col_select not one-hot
//   err_clr      clears both error flags (wins over a same-cycle set)
// -----------------------------------------------------------------------------
module matrix_frame_capture (
    input  logic       clk,
    input  logic       reset,
    input  logic       DS,
    input  logic       SH_CP,
    input  logic       ST_CP,
    input  logic       reset_out,
    input  logic [7:0] col_select,
    input  logic [2:0] rd_col,
    input  logic       err_clr,
    output logic [7:0] rd_red,
    output logic [7:0] rd_green,
    output logic [7:0] rd_blue,
    output logic [7:0] col_valid,
    output logic       frame_done,
    output logic [7:0] frame_count,
    output logic       err_len,
    output logic       err_col
);

    localparam int          PIN_W    = 12;
    localparam logic [4:0]  WORD_LEN = 5'd24;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Bit counter saturates at 31 so long bursts cannot wrap back to 24.
    function automatic logic [4:0] cnt_sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic [PIN_W-1:0] pins_raw;
    logic [PIN_W-1:0] pins_in;

    assign pins_raw = {DS, SH_CP, ST_CP, reset_out, col_select};

`ifdef MATRIX_CAPTURE_SYNC_EN
    logic [PIN_W-1:0] meta_q;
    logic [PIN_W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pins_raw;
            sync_q <= meta_q;
        end
    end

    assign pins_in = sync_q;
`else
    assign pins_in = pins_raw;
`endif

    logic [PIN_W-1:0] s1_q;
    logic [1:0]       s2_q;     // only the two clocks need a second stage for edge detect

    logic       ds_s1;
    logic       sh_s1;
    logic       st_s1;
    logic       rstout_s1;
    logic [7:0] col_s1;
    logic       sh_rise;
    logic       st_rise;

    assign ds_s1     = s1_q[11];
    assign sh_s1     = s1_q[10];
    assign st_s1     = s1_q[9];
    assign rstout_s1 = s1_q[8];
    assign col_s1    = s1_q[7:0];
    assign sh_rise   = sh_s1 & ~s2_q[1];
    assign st_rise   = st_s1 & ~s2_q[0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [23:0] sr_q,        sr_d;
    logic [4:0]  bit_cnt_q,   bit_cnt_d;
    logic [23:0] fb_q [8];
    logic [23:0] fb_d [8];
    logic [7:0]  col_valid_q, col_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        err_len_q,   err_len_d;
    logic        err_col_q,   err_col_d;
    logic [23:0] rd_q,        rd_d;

    logic        err_len_set;
    logic        err_col_set;
    logic [7:0]  valid_next;

    always_comb begin
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        fb_d          = fb_q;
        col_valid_d   = col_valid_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        err_len_set   = 1'b0;
        err_col_set   = 1'b0;
        valid_next    = col_valid_q;

        if (!rstout_s1) begin
            // Driver is holding its shift register in reset: drop partial
            // bits and ignore both clocks; stored frame data is kept.
            sr_d      = 24'd0;
            bit_cnt_d = 5'd0;
        end else begin
            if (sh_rise) begin
                sr_d      = {sr_q[22:0], ds_s1};
                bit_cnt_d = cnt_sat_inc(bit_cnt_q);
            end

            // Latch uses the pre-shift sr/bit_cnt, like the 74HC595 when
            // both clocks rise together.
            if (st_rise) begin
                bit_cnt_d = sh_rise ? 5'd1 : 5'd0;
                if (bit_cnt_q != WORD_LEN) err_len_set = 1'b1;

                if (is_onehot(col_s1)) begin
                    fb_d[onehot_index(col_s1)] = sr_q;
                    valid_next = col_valid_q | col_s1;
                    if (valid_next == 8'hFF) begin
                        col_valid_d   = 8'h00;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                    end else begin
                        col_valid_d   = valid_next;
                    end
                end else begin
                    err_col_set = 1'b1;
                end
            end
        end

        err_len_d = err_clr ? 1'b0 : (err_len_q | err_len_set);
        err_col_d = err_clr ? 1'b0 : (err_col_q | err_col_set);

        rd_d = fb_q[rd_col];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            fb_q          <= '{default: '0};
            col_valid_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_len_q     <= 1'b0;
            err_col_q     <= 1'b0;
            rd_q          <= '0;
        end else begin
            s1_q          <= pins_in;
            s2_q          <= {sh_s1, st_s1};
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            fb_q          <= fb_d;
            col_valid_q   <= col_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_len_q     <= err_len_d;
            err_col_q     <= err_col_d;
            rd_q          <= rd_d;
        end
    end

    assign rd_red      = rd_q[23:16];
    assign rd_green    = rd_q[15:8];
    assign rd_blue     = rd_q[7:0];
    assign col_valid   = col_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_len     = err_len_q;
    assign err_col     = err_col_q;

endmodule
